// File: rtl/axi_pkg.sv
// Shared AXI encodings: burst types, response codes and the write-slave FSM states.
package axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_RESP
   } state_e;

   // Legal WRAP burst lengths are 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_addr.sv
// Next-beat byte address for AXI FIXED/INCR/WRAP bursts; INCR stays inside its 4 KB page.
module axi_addr
   import axi_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] i_addr,
   input  logic [2:0]    i_size,
   input  logic [1:0]    i_burst,
   input  logic [7:0]    i_len,
   output logic [AW-1:0] o_next_addr
);

   localparam logic [AW-1:0] ONE = AW'(1);

   logic [AW-1:0] step;
   logic [AW-1:0] aligned;
   logic [AW-1:0] incr;
   logic [AW-1:0] wrap_mask;

   always_comb begin
      step        = ONE << i_size;
      aligned     = i_addr & ~(step - ONE);
      incr        = aligned + step;
      wrap_mask   = ((AW'(i_len) + ONE) << i_size) - ONE;
      o_next_addr = i_addr;
      case (i_burst)
         BURST_INCR: o_next_addr = {i_addr[AW-1:12], incr[11:0]};
         BURST_WRAP: o_next_addr = (i_addr & ~wrap_mask) | (incr & wrap_mask);
         default:    o_next_addr = i_addr;
      endcase
   end

endmodule

// File: rtl/axi_wr_slave.sv
// AXI4 write-channel responder: one burst at a time, registered memory write port,
// one B response per burst (SLVERR for illegal or mis-terminated bursts).
module axi_wr_slave
   import axi_pkg::*;
#(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int IDW    = 4,
   parameter int MEM_AW = 10
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [IDW-1:0]    i_awid,
   input  logic [AW-1:0]     i_awaddr,
   input  logic [7:0]        i_awlen,
   input  logic [2:0]        i_awsize,
   input  logic [1:0]        i_awburst,
   input  logic              i_awvalid,
   output logic              o_awready,
   input  logic [DW-1:0]     i_wdata,
   input  logic [DW/8-1:0]   i_wstrb,
   input  logic              i_wlast,
   input  logic              i_wvalid,
   output logic              o_wready,
   output logic [IDW-1:0]    o_bid,
   output logic [1:0]        o_bresp,
   output logic              o_bvalid,
   input  logic              i_bready,
   output logic              o_mem_we,
   output logic [MEM_AW-1:0] o_mem_addr,
   output logic [DW-1:0]     o_mem_wdata,
   output logic [DW/8-1:0]   o_mem_wstrb
);

   localparam int         OFF      = $clog2(DW / 8);
   localparam logic [2:0] MAX_SIZE = 3'(OFF);

   state_e            state_q, state_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [AW-1:0]     next_addr;
   logic [7:0]        len_q, len_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [2:0]        size_q, size_d;
   logic [1:0]        burst_q, burst_d;
   logic              err_q, err_d;
   logic              mem_we_q, mem_we_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
   logic [DW/8-1:0]   mem_wstrb_q, mem_wstrb_d;
   logic              cnt_done;

   axi_addr #(.AW(AW)) u_addr (
      .i_addr      (addr_q),
      .i_size      (size_q),
      .i_burst     (burst_q),
      .i_len       (len_q),
      .o_next_addr (next_addr)
   );

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      addr_d      = addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      burst_d     = burst_q;
      err_d       = err_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      cnt_done    = (cnt_q == len_q);
      case (state_q)
         ST_IDLE: begin
            if (i_awvalid) begin
               id_d    = i_awid;
               addr_d  = i_awaddr;
               len_d   = i_awlen;
               size_d  = i_awsize;
               burst_d = i_awburst;
               cnt_d   = 8'd0;
               err_d   = (i_awburst == BURST_RSVD) || (i_awsize > MAX_SIZE) ||
                         ((i_awburst == BURST_WRAP) && !wrap_len_ok(i_awlen));
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (i_wvalid) begin
               // Bursts rejected at AW time are drained without touching memory.
               mem_we_d    = ~err_q;
               mem_addr_d  = addr_q[MEM_AW+OFF-1:OFF];
               mem_wdata_d = i_wdata;
               mem_wstrb_d = err_q ? '0 : i_wstrb;
               addr_d      = next_addr;
               cnt_d       = cnt_q + 8'd1;
               if (i_wlast || cnt_done) begin
                  if (i_wlast != cnt_done) begin
                     err_d = 1'b1;
                  end
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (i_bready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         err_q       <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         err_q       <= err_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
      end
   end

   // AW readiness is held low for as long as reset is asserted.
   assign o_awready   = (state_q == ST_IDLE) && i_rst_n;
   assign o_wready    = (state_q == ST_DATA);
   assign o_bvalid    = (state_q == ST_RESP);
   assign o_bid       = id_q;
   assign o_bresp     = err_q ? RESP_SLVERR : RESP_OKAY;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Self-checking bench for axi_wr_slave: directed vector table, mid-burst reset and
// randomized bursts checked against an address/response model of AXI burst rules.
module tb_axi_wr_slave;

   localparam int TMO = 64;

   logic        i_clk;
   logic        i_rst_n;
   logic [3:0]  i_awid;
   logic [31:0] i_awaddr;
   logic [7:0]  i_awlen;
   logic [2:0]  i_awsize;
   logic [1:0]  i_awburst;
   logic        i_awvalid;
   logic        o_awready;
   logic [31:0] i_wdata;
   logic [3:0]  i_wstrb;
   logic        i_wlast;
   logic        i_wvalid;
   logic        o_wready;
   logic [3:0]  o_bid;
   logic [1:0]  o_bresp;
   logic        o_bvalid;
   logic        i_bready;
   logic        o_mem_we;
   logic [9:0]  o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_wstrb;

   typedef struct {
      logic [3:0]       id;
      logic [31:0]      addr;
      logic [7:0]       len;
      logic [2:0]       size;
      logic [1:0]       burst;
      int               wlastIdx;
      int               bDly;
      logic [31:0]      dBase;
      logic [3:0][3:0]  strbs;
      logic [1:0]       expResp;
      int               expN;
      logic [3:0][9:0]  expWa;
   } vec_t;

   typedef struct packed {
      logic [9:0]  wa;
      logic [31:0] d;
      logic [3:0]  s;
   } wr_t;

   vec_t vecs[10];
   wr_t  memQ[$];
   int   nCompared;
   int   nMismatched;

   axi_wr_slave #(.AW(32), .DW(32), .IDW(4), .MEM_AW(10)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_awid      (i_awid),
      .i_awaddr    (i_awaddr),
      .i_awlen     (i_awlen),
      .i_awsize    (i_awsize),
      .i_awburst   (i_awburst),
      .i_awvalid   (i_awvalid),
      .o_awready   (o_awready),
      .i_wdata     (i_wdata),
      .i_wstrb     (i_wstrb),
      .i_wlast     (i_wlast),
      .i_wvalid    (i_wvalid),
      .o_wready    (o_wready),
      .o_bid       (o_bid),
      .o_bresp     (o_bresp),
      .o_bvalid    (o_bvalid),
      .i_bready    (i_bready),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .o_mem_wstrb (o_mem_wstrb)
   );

   // Free-running 100 MHz clock.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Record every memory write pulse; outputs are registered so the falling edge sees stable values.
   always @(negedge i_clk) begin
      if (o_mem_we) begin
         memQ.push_back('{wa: o_mem_addr, d: o_mem_wdata, s: o_mem_wstrb});
      end
   end

   // Watchdog so a stuck handshake can never hang the run.
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endfunction

   // Word address of beat i, derived from the AXI burst address rules with plain arithmetic.
   function automatic logic [9:0] modelWa(input logic [31:0] a, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst, input int i);
      longint     nb, al, wb, lo, ba;
      logic [63:0] bv;
      nb = longint'(1) << size;
      al = (longint'(a) / nb) * nb;
      if (i == 0 || burst == 2'b00) begin
         ba = longint'(a);
      end else if (burst == 2'b01) begin
         ba = (longint'(a) / 4096) * 4096 + ((al % 4096) + i * nb) % 4096;
      end else begin
         wb = (longint'(len) + 1) * nb;
         lo = (longint'(a) / wb) * wb;
         ba = lo + ((al - lo) + i * nb) % wb;
      end
      bv = ba;
      return bv[11:2];
   endfunction

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_awready"}, o_awready, 0);
      checkOutput({tag, "_wready"}, o_wready, 0);
      checkOutput({tag, "_bvalid"}, o_bvalid, 0);
      checkOutput({tag, "_bid"}, o_bid, 0);
      checkOutput({tag, "_bresp"}, o_bresp, 0);
      checkOutput({tag, "_mem_we"}, o_mem_we, 0);
      checkOutput({tag, "_mem_addr"}, o_mem_addr, 0);
      checkOutput({tag, "_mem_wdata"}, o_mem_wdata, 0);
      checkOutput({tag, "_mem_wstrb"}, o_mem_wstrb, 0);
   endtask

   // Drive one full AW/W/B transaction; must be entered just after a falling edge.
   task automatic applyStimulus(input string tag, input logic [3:0] id, input logic [31:0] addr,
                                input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                                input int wlastIdx, input int bDly, input logic [31:0] dBase,
                                input logic [3:0][3:0] strbs, input bit expWe, input bit gaps,
                                input logic [1:0] expResp);
      int t;
      int last;
      last      = (wlastIdx < int'(len)) ? wlastIdx : int'(len);
      i_awid    = id;
      i_awaddr  = addr;
      i_awlen   = len;
      i_awsize  = size;
      i_awburst = burst;
      i_awvalid = 1'b1;
      t = 0;
      while (!o_awready && t < TMO) begin
         @(negedge i_clk);
         t++;
      end
      if (!o_awready) begin
         checkOutput({tag, "_aw_timeout"}, 0, 1);
         i_awvalid = 1'b0;
         return;
      end
      @(negedge i_clk);
      i_awvalid = 1'b0;
      checkOutput({tag, "_awready_busy"}, o_awready, 0);
      for (int b = 0; b <= last; b++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
         end
         i_wvalid = 1'b1;
         i_wdata  = dBase + 32'(b);
         i_wstrb  = strbs[b % 4];
         i_wlast  = (b == wlastIdx);
         t = 0;
         while (!o_wready && t < TMO) begin
            @(negedge i_clk);
            t++;
         end
         if (!o_wready) begin
            checkOutput($sformatf("%s_w%0d_timeout", tag, b), 0, 1);
            i_wvalid = 1'b0;
            i_wlast  = 1'b0;
            return;
         end
         @(negedge i_clk);
         i_wvalid = 1'b0;
         i_wlast  = 1'b0;
         checkOutput($sformatf("%s_we_beat%0d", tag, b), o_mem_we, expWe);
      end
      checkOutput({tag, "_bvalid_rise"}, o_bvalid, 1);
      for (int d = 0; d < bDly; d++) begin
         @(negedge i_clk);
         checkOutput($sformatf("%s_bvalid_hold%0d", tag, d), o_bvalid, 1);
      end
      i_bready = 1'b1;
      t = 0;
      while (!o_bvalid && t < TMO) begin
         @(negedge i_clk);
         t++;
      end
      checkOutput({tag, "_bvalid"}, o_bvalid, 1);
      checkOutput({tag, "_bid"}, o_bid, id);
      checkOutput({tag, "_bresp"}, o_bresp, expResp);
      @(negedge i_clk);
      i_bready = 1'b0;
      checkOutput({tag, "_awready_after_b"}, o_awready, 1);
   endtask

   task automatic checkModelWrites(input string tag, input logic [31:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst, input int expN,
                                   input logic [31:0] dBase, input logic [3:0][3:0] strbs);
      checkOutput({tag, "_nwrites"}, memQ.size(), expN);
      for (int j = 0; j < expN && j < memQ.size(); j++) begin
         checkOutput($sformatf("%s_wa%0d", tag, j), memQ[j].wa, modelWa(addr, len, size, burst, j));
         checkOutput($sformatf("%s_wd%0d", tag, j), memQ[j].d, dBase + 32'(j));
         checkOutput($sformatf("%s_ws%0d", tag, j), memQ[j].s, strbs[j % 4]);
      end
   endtask

   // Main sequence: reset, directed table, mid-burst reset, then random bursts.
   initial begin
      logic [3:0]      rId;
      logic [31:0]     rAddr, rBase;
      logic [7:0]      rLen;
      logic [2:0]      rSize;
      logic [1:0]      rBurst;
      logic [3:0][3:0] rStrbs;
      int              rWl, rLast, rN, k;
      bit              rErr;
      logic [1:0]      rResp;

      nCompared   = 0;
      nMismatched = 0;
      i_rst_n   = 1'b0;
      i_awid    = '0;
      i_awaddr  = '0;
      i_awlen   = '0;
      i_awsize  = '0;
      i_awburst = '0;
      i_awvalid = 1'b0;
      i_wdata   = '0;
      i_wstrb   = '0;
      i_wlast   = 1'b0;
      i_wvalid  = 1'b0;
      i_bready  = 1'b0;

      vecs[0] = '{4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 3, 0, 32'h0000_00A0, {4{4'hF}}, 2'b00, 4,
                  {10'h043, 10'h042, 10'h041, 10'h040}};
      vecs[1] = '{4'h3, 32'h038, 8'd3, 3'd2, 2'b10, 3, 1, 32'h0000_1000, {4{4'hF}}, 2'b00, 4,
                  {10'h00D, 10'h00C, 10'h00F, 10'h00E}};
      vecs[2] = '{4'h9, 32'h020, 8'd2, 3'd2, 2'b00, 2, 0, 32'h55AA_0000, {4'hF, 4'hC, 4'h3, 4'h1}, 2'b00, 3,
                  {10'h000, 10'h008, 10'h008, 10'h008}};
      vecs[3] = '{4'h7, 32'h200, 8'd3, 3'd2, 2'b01, 1, 0, 32'h0000_2000, {4{4'hF}}, 2'b10, 2,
                  {10'h000, 10'h000, 10'h081, 10'h080}};
      vecs[4] = '{4'h2, 32'h040, 8'd1, 3'd2, 2'b11, 1, 5, 32'h0000_3000, {4{4'hF}}, 2'b10, 0,
                  {10'h000, 10'h000, 10'h000, 10'h000}};
      vecs[5] = '{4'h1, 32'h300, 8'd1, 3'd2, 2'b01, 9, 0, 32'h0000_4000, {4{4'h6}}, 2'b10, 2,
                  {10'h000, 10'h000, 10'h0C1, 10'h0C0}};
      vecs[6] = '{4'hE, 32'h040, 8'd2, 3'd2, 2'b10, 2, 2, 32'h0000_5000, {4{4'hF}}, 2'b10, 0,
                  {10'h000, 10'h000, 10'h000, 10'h000}};
      vecs[7] = '{4'hA, 32'hFF8, 8'd3, 3'd2, 2'b01, 3, 0, 32'h0000_6000, {4'h8, 4'h4, 4'h2, 4'h1}, 2'b00, 4,
                  {10'h001, 10'h000, 10'h3FF, 10'h3FE}};
      vecs[8] = '{4'h4, 32'h080, 8'd1, 3'd3, 2'b01, 1, 0, 32'h0000_7000, {4{4'hF}}, 2'b10, 0,
                  {10'h000, 10'h000, 10'h000, 10'h000}};
      vecs[9] = '{4'hB, 32'h101, 8'd3, 3'd0, 2'b01, 3, 0, 32'h0000_8000, {4'h1, 4'h8, 4'h4, 4'h2}, 2'b00, 4,
                  {10'h041, 10'h040, 10'h040, 10'h040}};

      #3;
      checkResetOutputs("rst");
      #9 i_rst_n = 1'b1;
      #1 checkOutput("awready_post_rst", o_awready, 1);
      @(negedge i_clk);

      for (int i = 0; i < 10; i++) begin
         memQ.delete();
         applyStimulus($sformatf("v%0d", i), vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size,
                       vecs[i].burst, vecs[i].wlastIdx, vecs[i].bDly, vecs[i].dBase, vecs[i].strbs,
                       vecs[i].expN > 0, 1'b0, vecs[i].expResp);
         checkOutput($sformatf("v%0d_nwrites", i), memQ.size(), vecs[i].expN);
         for (int j = 0; j < vecs[i].expN && j < memQ.size(); j++) begin
            checkOutput($sformatf("v%0d_wa%0d", i, j), memQ[j].wa, vecs[i].expWa[j]);
            checkOutput($sformatf("v%0d_wd%0d", i, j), memQ[j].d, vecs[i].dBase + 32'(j));
            checkOutput($sformatf("v%0d_ws%0d", i, j), memQ[j].s, vecs[i].strbs[j]);
         end
      end

      // Reset in the middle of a burst, right after a beat has been registered to memory.
      i_awid    = 4'h6;
      i_awaddr  = 32'h400;
      i_awlen   = 8'd7;
      i_awsize  = 3'd2;
      i_awburst = 2'b01;
      i_awvalid = 1'b1;
      checkOutput("mr_awready", o_awready, 1);
      @(negedge i_clk);
      i_awvalid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         i_wvalid = 1'b1;
         i_wdata  = 32'hDEAD_0000 + 32'(b);
         i_wstrb  = 4'hF;
         @(negedge i_clk);
      end
      checkOutput("mr_we_before", o_mem_we, 1);
      #2 i_rst_n = 1'b0;
      #1 checkResetOutputs("midrst");
      i_wvalid = 1'b0;
      @(negedge i_clk);
      #2 i_rst_n = 1'b1;
      @(negedge i_clk);
      memQ.delete();
      applyStimulus("post_rst", 4'hC, 32'h500, 8'd3, 3'd2, 2'b01, 3, 0, 32'h0BAD_0000, {4{4'hF}},
                    1'b1, 1'b0, 2'b00);
      checkModelWrites("post_rst", 32'h500, 8'd3, 3'd2, 2'b01, 4, 32'h0BAD_0000, {4{4'hF}});

      for (int r = 0; r < 40; r++) begin
         k      = $urandom_range(0, 9);
         rBurst = (k < 4) ? 2'b01 : (k < 7) ? 2'b10 : (k < 9) ? 2'b00 : 2'b11;
         rSize  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         if (rBurst == 2'b10 && $urandom_range(0, 7) != 0) begin
            rLen = 8'((2 << $urandom_range(0, 3)) - 1);
         end else if ($urandom_range(0, 9) == 0) begin
            rLen = 8'($urandom_range(16, 255));
         end else begin
            rLen = 8'($urandom_range(0, 15));
         end
         rAddr = $urandom & 32'h0000_3FFF;
         if (rBurst == 2'b10) begin
            rAddr = rAddr & ~((32'd1 << rSize) - 32'd1);
         end
         rWl    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(rLen) + 2)) : int'(rLen);
         rId    = 4'($urandom);
         rBase  = $urandom;
         rStrbs = 16'($urandom);
         rErr   = (rBurst == 2'b11) || (rSize > 3'd2) ||
                  (rBurst == 2'b10 && !(rLen == 8'd1 || rLen == 8'd3 || rLen == 8'd7 || rLen == 8'd15));
         rLast  = (rWl < int'(rLen)) ? rWl : int'(rLen);
         rResp  = (rErr || rWl != int'(rLen)) ? 2'b10 : 2'b00;
         rN     = rErr ? 0 : rLast + 1;
         memQ.delete();
         applyStimulus($sformatf("r%0d", r), rId, rAddr, rLen, rSize, rBurst, rWl,
                       $urandom_range(0, 3), rBase, rStrbs, !rErr, 1'b1, rResp);
         checkModelWrites($sformatf("r%0d", r), rAddr, rLen, rSize, rBurst, rN, rBase, rStrbs);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/axi_wr_slave.md
# axi_wr_slave

AXI4 write-channel responder: accepts one write burst at a time on AW/W, drives a registered single-port memory write interface beat by beat, and returns one B response per burst. It is the slave-side counterpart of the DMA write master and the endpoint for DMA write traffic in block-level and loopback tests. Per-beat addresses follow AXI FIXED/INCR/WRAP rules through the shared `axi_addr` helper.

## Interface
- AW, default 32, AXI address width
- DW, default 32, data width (8..1024, power of two)
- IDW, default 4, AXI ID width
- MEM_AW, default 10, memory word-address width
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous assert, active-low
- i_awid  in  IDW  write burst ID
- i_awaddr  in  AW  start byte address
- i_awlen  in  8  beats minus one
- i_awsize  in  3  log2 bytes per beat
- i_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- i_awvalid / o_awready  in / out  1  AW handshake
- i_wdata  in  DW  write data
- i_wstrb  in  DW/8  byte strobes
- i_wlast  in  1  last beat flag
- i_wvalid / o_wready  in / out  1  W handshake
- o_bid  out  IDW  response ID
- o_bresp  out  2  00 OKAY, 10 SLVERR
- o_bvalid / i_bready  out / in  1  B handshake
- o_mem_we  out  1  memory write enable, one cycle per accepted beat
- o_mem_addr  out  MEM_AW  word address = beat address[MEM_AW+log2(DW/8)-1 : log2(DW/8)]
- o_mem_wdata  out  DW  registered copy of i_wdata
- o_mem_wstrb  out  DW/8  registered copy of i_wstrb; forced to 0 on error bursts

## Operation
- FSM states: IDLE, DATA, RESP. Reset -> IDLE.
- IDLE: o_awready=1. On AW handshake, latch id, addr, len, size, burst; clear beat counter and error flag; go to DATA.
- Error flag is set at AW accept if burst==11, size > log2(DW/8), or burst==WRAP with len not in {1,3,7,15}. Error bursts are fully consumed but never write memory (o_mem_we stays 0).
- DATA: o_wready=1. Each W handshake: register data/strobe/address to the memory port, increment the beat counter, advance the address via `axi_addr`(current addr, size, burst, len).
- Burst ends on the first handshake where i_wlast=1 or counter==len. If these disagree (early wlast, or missing wlast at counter==len), set the error flag. Go to RESP.
- RESP: o_bvalid=1, o_bid=latched id, o_bresp=SLVERR if error flag set else OKAY. On B handshake, go to IDLE.
- Only one burst is outstanding; AW is not accepted while in DATA or RESP.
- Arithmetic: beat counter is 8 bits and compared to len with no overflow (max 256 beats). Address advance never crosses a 4 KB boundary (handled in `axi_addr`).

## Timing
- Reset values: o_awready=0 while asserted, 1 in the first cycle after release; o_wready=0, o_bvalid=0, o_bid=0, o_bresp=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_wstrb=0.
- o_awready, o_wready, and o_bvalid are registered state decodes with no combinational path from valid inputs.
- Memory write lags the W handshake by exactly 1 cycle.
- o_bvalid rises in the cycle after the last W handshake and holds until i_bready.
- Sustained W throughput is 1 beat per cycle.
- Minimum burst turnaround: AW accept (cycle 0), W beats (cycles 1..len+1), B valid (cycle len+2), o_awready (cycle after the B handshake).
- Reset mid-burst: return to IDLE immediately; the pending memory write and response are dropped.

## Structure
- Shared package `axi_pkg` holds the burst encodings (FIXED/INCR/WRAP), resp codes (OKAY/SLVERR), and FSM state encodings.
- Instantiate the existing `axi_addr` once for next-address generation. No other sub-modules.

## Test plan
- INCR, awaddr=0x100, len=3, size=2, DW=32, 4 beats 0xA0..0xA3 -> mem writes at word addrs 0x40..0x43, BRESP=OKAY, bid echoed.
- WRAP, awaddr=0x38, len=3, size=2 -> word addrs 0x0E, 0x0F, 0x0C, 0x0D; OKAY.
- FIXED, awaddr=0x20, len=2 -> three writes to word 0x08 with the given strobes; OKAY.
- Early wlast on beat 2 of len=3 -> burst ends after 2 writes, BRESP=SLVERR; next AW accepted after the B handshake.
- burst=11, len=1 -> 2 beats accepted, o_mem_we never asserted, SLVERR; bready held low 5 cycles -> bvalid stays high and stable.
- Reset asserted mid-DATA -> all outputs return to reset values asynchronously; a fresh INCR burst after release completes with OKAY.
